// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared widths, FIFO entry layout, stall FSM states and a register one-hot decoder
// for the regfile write-port arbiter.
package regfile_wr_arbiter_pkg;

    localparam int RF_AW   = 5;
    localparam int RF_DW   = 32;
    localparam int RF_REGS = 1 << RF_AW;

    typedef struct packed {
        logic             valid;
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } rf_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAITING = 2'd1,
        ST_STALL   = 2'd2
    } arb_state_e;

    function automatic logic [RF_REGS-1:0] onehot(input logic [RF_AW-1:0] a);
        logic [RF_REGS-1:0] oh;
        oh    = '0;
        oh[a] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_wr_fifo.sv
// LU result FIFO: DEPTH entries, head peek, and per-entry valid clear on a write-back
// address match so a younger write-back kills the older queued result.
module regfile_wr_arbiter_wr_fifo
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [RF_AW-1:0]             push_addr,
    input  logic [RF_DW-1:0]             push_data,
    input  logic                         pop,
    input  logic                         clr_en,
    input  logic [RF_AW-1:0]             clr_addr,
    output rf_entry_t                    head,
    output logic                         empty,
    output logic                         full,
    output rf_entry_t                    entries [DEPTH],
    output logic [$clog2(DEPTH+1)-1:0]   clr_num
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = $clog2(DEPTH + 1);

    rf_entry_t      mem_q [DEPTH];
    rf_entry_t      mem_d [DEPTH];
    logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Clear first, then push: an entry written this cycle is never hit by this cycle's clear.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        clr_num = '0;
        if (clr_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].valid && (mem_q[i].addr == clr_addr)) begin
                    mem_d[i].valid = 1'b0;
                    clr_num        = clr_num + NW'(1);
                end
            end
        end
        if (pop) begin
            mem_d[rd_q].valid = 1'b0;
            rd_d              = rd_q + PW'(1);
        end
        if (push) begin
            mem_d[wr_q] = '{valid: 1'b1, addr: push_addr, data: push_data};
            wr_d        = wr_q + PW'(1);
        end
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head    = mem_q[rd_q];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign entries = mem_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Regfile write-port arbiter: write-back always wins, LU results queue and drain into idle
// port cycles; a starvation FSM raises a registered stall request to force a bubble.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8,
    parameter int AW       = RF_AW,
    parameter int DW       = RF_DW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_waddr,
    input  logic [DW-1:0]     wb_wdata,
    input  logic              lu_valid,
    output logic              lu_ready,
    input  logic [AW-1:0]     lu_waddr,
    input  logic [DW-1:0]     lu_wdata,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic [2**AW-1:0]  pend_mask,
    output logic              stall_req,
    output logic [7:0]        cancel_cnt,
    output arb_state_e        dbg_state
);

    // LU handshake: a result transfers on any cycle with lu_valid && lu_ready; lu_ready is
    // !full of the current cycle (no pop-to-push bypass), and r0 results handshake but are dropped.

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

    logic                         wb_active, head_valid, blocked;
    logic                         push, pop, empty, full;
    rf_entry_t                    head;
    rf_entry_t                    entries [DEPTH];
    logic [$clog2(DEPTH+1)-1:0]   clr_num;
    arb_state_e                   state_q, state_d;
    logic [WCW-1:0]               wait_q, wait_d;
    logic [7:0]                   cancel_q, cancel_d;
    logic [8:0]                   cancel_sum;

    assign wb_active  = rst && wb_we && (wb_waddr != '0);
    assign head_valid = !empty && head.valid;
    assign blocked    = head_valid && wb_active;
    assign lu_ready   = !full;
    assign push       = lu_valid && !full && (lu_waddr != '0);
    // A cancelled head pops even while write-back owns the port.
    assign pop        = !empty && !blocked;

    regfile_wr_arbiter_wr_fifo #(.DEPTH(DEPTH)) u_wr_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (lu_waddr),
        .push_data (lu_wdata),
        .pop       (pop),
        .clr_en    (wb_active),
        .clr_addr  (wb_waddr),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .entries   (entries),
        .clr_num   (clr_num)
    );

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (wb_active) begin
            rf_we    = 1'b1;
            rf_waddr = wb_waddr;
            rf_wdata = wb_wdata;
        end else if (head_valid) begin
            rf_we    = 1'b1;
            rf_waddr = head.addr;
            rf_wdata = head.data;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid) pend_mask = pend_mask | onehot(entries[i].addr);
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        if (blocked) wait_d = (wait_q == WAIT_LAST) ? wait_q : wait_q + WCW'(1);
        case (state_q)
            ST_IDLE, ST_WAITING: begin
                if (blocked && (wait_q == WAIT_LAST)) state_d = ST_STALL;
                else if (blocked)                     state_d = ST_WAITING;
                else                                  state_d = ST_IDLE;
            end
            ST_STALL: if (!blocked) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        cancel_sum = {1'b0, cancel_q} + 9'(clr_num);
        cancel_d   = cancel_sum[8] ? 8'hFF : cancel_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            cancel_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            cancel_q <= cancel_d;
        end
    end

    assign stall_req  = (state_q == ST_STALL);
    assign cancel_cnt = cancel_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scenario bench for regfile_wr_arbiter: expected regfile writes are queued as stimulus is
// driven and matched against every rf_we cycle; scenario tasks check the side outputs inline.
module tb_regfile_wr_arbiter;
    import regfile_wr_arbiter_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;

    logic             clk, rst;
    logic             wb_we, lu_valid, lu_ready, rf_we, stall_req;
    logic [AW-1:0]    wb_waddr, lu_waddr, rf_waddr;
    logic [DW-1:0]    wb_wdata, lu_wdata, rf_wdata;
    logic [31:0]      pend_mask;
    logic [7:0]       cancel_cnt;
    arb_state_e       dbg_state;

    int checks = 0;
    int errors = 0;
    int exp_cancel = 0;
    logic [AW+DW-1:0] exp_q[$];
    logic [DW-1:0]    shadow [32];

    regfile_wr_arbiter #(.DEPTH(4), .MAX_WAIT(8), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_mask(pend_mask), .stall_req(stall_req), .cancel_cnt(cancel_cnt),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 500000");
        $fatal(1);
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic drive_wb(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_we = en; wb_waddr = a; wb_wdata = d;
        if (en && (a != '0)) exp_q.push_back({a, d});
    endtask

    task automatic drive_lu(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        lu_valid = v; lu_waddr = a; lu_wdata = d;
    endtask

    task automatic expect_lu(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    // Scoreboard: every regfile write must match the oldest expected write
    task automatic monitor();
        logic [AW+DW-1:0] got, exp;
        forever begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                got = {rf_waddr, rf_wdata};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rf_write: got r%0d=%h, expected no write", rf_waddr, rf_wdata);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL rf_write: got r%0d=%h, expected r%0d=%h",
                                 rf_waddr, rf_wdata, exp[AW+DW-1:DW], exp[DW-1:0]);
                    end
                end
                shadow[rf_waddr] = rf_wdata;
            end
        end
    endtask

    task automatic test_reset_start();
        #2;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b, expected 0", rf_we); end
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_lu_ready: got %b, expected 1", lu_ready); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b, expected 0", stall_req); end
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL reset_pend_mask: got %h, expected 0", pend_mask); end
        checks++; if (cancel_cnt !== 8'd0) begin errors++; $display("FAIL reset_cancel_cnt: got %0d, expected 0", cancel_cnt); end
        at_neg();
        rst = 1'b1;
    endtask

    task automatic test_lu_only();
        step(); drive_lu(1'b1, 5'd5, 32'hA5A5_A5A5); expect_lu(5'd5, 32'hA5A5_A5A5);
        at_neg();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL lu_only_no_bypass: got rf_we=%b, expected 0", rf_we); end
        step(); drive_lu(1'b0, '0, '0);
        at_neg();
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL lu_only_write: got rf_we=%b, expected 1", rf_we); end
        checks++; if (pend_mask !== 32'h20) begin errors++; $display("FAIL lu_only_mask_set: got %h, expected 00000020", pend_mask); end
        step(); at_neg();
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL lu_only_mask_clear: got %h, expected 0", pend_mask); end
    endtask

    task automatic test_r0();
        step(); drive_lu(1'b1, 5'd0, 32'hDEAD_BEEF);
        at_neg();
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL r0_handshake: got lu_ready=%b, expected 1", lu_ready); end
        step(); drive_lu(1'b1, 5'd6, 32'h0000_6666);
        at_neg();
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL r0_not_stored: got mask %h, expected 0", pend_mask); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_no_write: got rf_we=%b, expected 0", rf_we); end
        step(); drive_lu(1'b0, '0, '0); drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF); expect_lu(5'd6, 32'h0000_6666);
        at_neg();
        checks++; if (pend_mask !== 32'h40) begin errors++; $display("FAIL r0_wb_does_not_block: got mask %h, expected 00000040", pend_mask); end
        step(); drive_wb(1'b0, '0, '0);
        at_neg();
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL r0_drained: got mask %h, expected 0", pend_mask); end
    endtask

    task automatic test_priority();
        int blocked;
        bit seen;
        step(); drive_wb(1'b1, 5'd3, $urandom); drive_lu(1'b1, 5'd7, 32'h0000_7777);
        at_neg();
        blocked = 0;
        seen    = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(); drive_lu(1'b0, '0, '0);
            if (stall_req === 1'b1) seen = 1'b1;
            else begin
                drive_wb(1'b1, 5'd3, $urandom);
                blocked++;
                at_neg();
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL prio_stall_seen: got no stall_req in 20 cycles, expected stall"); end
        checks++; if (blocked != 8) begin errors++; $display("FAIL prio_stall_delay: got %0d blocked cycles, expected 8", blocked); end
        checks++; if (dbg_state !== ST_STALL) begin errors++; $display("FAIL prio_state: got %0d, expected %0d", dbg_state, ST_STALL); end
        drive_wb(1'b0, '0, '0); expect_lu(5'd7, 32'h0000_7777);
        at_neg();
        checks++; if (pend_mask !== 32'h80) begin errors++; $display("FAIL prio_mask: got %h, expected 00000080", pend_mask); end
        step();
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL prio_stall_drop: got %b, expected 0", stall_req); end
        at_neg();
    endtask

    task automatic test_waw();
        step(); drive_wb(1'b1, 5'd3, $urandom); drive_lu(1'b1, 5'd9, 32'd1);
        at_neg();
        step(); drive_lu(1'b0, '0, '0); drive_wb(1'b1, 5'd9, 32'd2);
        at_neg();
        checks++; if (cancel_cnt !== 8'(exp_cancel)) begin errors++; $display("FAIL waw_cnt_before: got %0d, expected %0d", cancel_cnt, exp_cancel); end
        exp_cancel += 1;
        step(); drive_wb(1'b0, '0, '0);
        at_neg();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL waw_silent_pop: got rf_we=%b, expected 0", rf_we); end
        checks++; if (cancel_cnt !== 8'(exp_cancel)) begin errors++; $display("FAIL waw_cnt: got %0d, expected %0d", cancel_cnt, exp_cancel); end
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL waw_mask: got %h, expected 0", pend_mask); end
        checks++; if (shadow[9] !== 32'd2) begin errors++; $display("FAIL waw_r9_final: got %h, expected 2", shadow[9]); end
        // Two queued entries for one register both die on a single write-back
        step(); drive_wb(1'b1, 5'd3, $urandom); drive_lu(1'b1, 5'd12, 32'd1);
        at_neg();
        step(); drive_wb(1'b1, 5'd3, $urandom); drive_lu(1'b1, 5'd12, 32'd3);
        at_neg();
        step(); drive_wb(1'b1, 5'd12, 32'd4); drive_lu(1'b0, '0, '0);
        at_neg();
        exp_cancel += 2;
        step(); drive_wb(1'b0, '0, '0);
        at_neg(); step(); at_neg();
        checks++; if (cancel_cnt !== 8'(exp_cancel)) begin errors++; $display("FAIL waw_double_cnt: got %0d, expected %0d", cancel_cnt, exp_cancel); end
        // An entry pushed in the same cycle as the write-back survives
        step(); drive_wb(1'b1, 5'd10, 32'h0000_000A); drive_lu(1'b1, 5'd10, 32'h0000_000B);
        at_neg();
        step(); drive_wb(1'b0, '0, '0); drive_lu(1'b0, '0, '0); expect_lu(5'd10, 32'h0000_000B);
        at_neg();
        checks++; if (cancel_cnt !== 8'(exp_cancel)) begin errors++; $display("FAIL waw_same_cycle_cnt: got %0d, expected %0d", cancel_cnt, exp_cancel); end
        step(); at_neg();
        checks++; if (shadow[10] !== 32'h0000_000B) begin errors++; $display("FAIL waw_same_cycle_r10: got %h, expected 0000000b", shadow[10]); end
    endtask

    task automatic test_full();
        step(); drive_wb(1'b1, 5'd3, $urandom); drive_lu(1'b1, 5'd11, 32'hF000_0011);
        at_neg();
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_empty: got %b, expected 1", lu_ready); end
        for (int k = 12; k <= 14; k++) begin
            step(); drive_wb(1'b1, 5'd3, $urandom); drive_lu(1'b1, 5'(k), 32'hF000_0000 + 32'(k));
            at_neg();
        end
        step(); drive_wb(1'b1, 5'd3, $urandom); drive_lu(1'b1, 5'd15, 32'hF000_0015);
        at_neg();
        checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_not_ready: got %b, expected 0", lu_ready); end
        checks++; if (pend_mask !== 32'h0000_7800) begin errors++; $display("FAIL full_mask: got %h, expected 00007800", pend_mask); end
        step(); drive_wb(1'b1, 5'd3, $urandom);
        at_neg();
        checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_held: got %b, expected 0", lu_ready); end
        step(); drive_wb(1'b0, '0, '0); expect_lu(5'd11, 32'hF000_0011);
        at_neg();
        checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_drain_cycle: got %b, expected 0", lu_ready); end
        step(); expect_lu(5'd12, 32'hF000_000C);
        at_neg();
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_accept: got %b, expected 1", lu_ready); end
        step(); drive_lu(1'b0, '0, '0); expect_lu(5'd13, 32'hF000_000D);
        at_neg();
        checks++; if (pend_mask !== 32'h0000_E000) begin errors++; $display("FAIL full_mask_after: got %h, expected 0000e000", pend_mask); end
        step(); expect_lu(5'd14, 32'hF000_000E); at_neg();
        step(); expect_lu(5'd15, 32'hF000_0015); at_neg();
        step(); at_neg();
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL full_empty_mask: got %h, expected 0", pend_mask); end
    endtask

    task automatic test_reset_mid();
        step(); drive_wb(1'b1, 5'd3, $urandom); drive_lu(1'b1, 5'd20, 32'h2020_2020);
        at_neg();
        step(); drive_wb(1'b1, 5'd3, $urandom); drive_lu(1'b1, 5'd21, 32'h2121_2121);
        at_neg();
        step(); rst = 1'b0; drive_wb(1'b0, '0, '0); drive_lu(1'b0, '0, '0);
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_reset_rf_we: got %b, expected 0", rf_we); end
        checks++; if (pend_mask !== 32'h0) begin errors++; $display("FAIL mid_reset_mask: got %h, expected 0", pend_mask); end
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_ready: got %b, expected 1", lu_ready); end
        checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL mid_reset_stall: got %b, expected 0", stall_req); end
        checks++; if (cancel_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_cancel: got %0d, expected 0", cancel_cnt); end
        exp_cancel = 0;
        at_neg(); step(); at_neg();
        rst = 1'b1;
        repeat (3) begin step(); at_neg(); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_reset_no_stale: got rf_we=%b, expected 0", rf_we); end
    endtask

    initial begin
        rst = 1'b0;
        wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
        lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        fork
            monitor();
        join_none
        test_reset_start();
        test_lu_only();
        test_r0();
        test_priority();
        test_waw();
        test_full();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d writes still expected, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
